// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump sequencer.
// Optional feature macro: REGDUMP_CHECKSUM_EN adds a trailing XOR checksum byte.
package regdump_pkg;

  localparam logic [7:0]  HEADER_BYTE_DEF = 8'hA5;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned BYTES_PER_WORD  = DATA_W_DEF / 8;

  // Number of bytes serialised per register word.
  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STALL,
    ST_HEADER,
    ST_LOAD,
    ST_SEND,
`ifdef REGDUMP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

endpackage

// File: rtl/regdump_byte_shifter.sv
// Load/shift register that presents one register word MSB byte first,
// with a byte counter flagging the final byte of the word.
module regdump_byte_shifter
  import regdump_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BYTES  = BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        msb_byte,
  output logic              last_byte
);

  localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  // Capture a word on load, move the next byte up to the MSB on each shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= din;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= sreg << 8;
      cnt  <= cnt + CW'(1);
    end
  end

  assign msb_byte  = sreg[DATA_W-1 -: 8];
  assign last_byte = (cnt == CW'(BYTES - 1));

endmodule

// File: rtl/regfile_dump_sequencer.sv
// Stalls the pipeline, waits for it to drain, then streams a header byte and
// every register value (big-endian) over a valid/ready byte interface.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum byte.
module regfile_dump_sequencer
  import regdump_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_req,
  input  logic              pipe_idle,
  output logic              stall_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  state_t      state, state_nxt;
  logic        load, shift, last_byte, last_reg;
  logic [7:0]  msb_byte;

  assign last_reg = (rd_addr == ADDR_W'(NUM_REGS - 1));

  regdump_byte_shifter #(
    .DATA_W (DATA_W),
    .BYTES  (bytes_per_word(DATA_W))
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .din       (rd_data),
    .msb_byte  (msb_byte),
    .last_byte (last_byte)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Register address walk: restart at 0 on a new dump, advance after each word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_addr <= '0;
    end else if (state == ST_IDLE && dump_req) begin
      rd_addr <= '0;
    end else if (state == ST_SEND && tx_ready && last_byte && !last_reg) begin
      rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of every accepted data byte; the header is not included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum <= '0;
    end else if (state == ST_IDLE) begin
      csum <= '0;
    end else if (state == ST_SEND && tx_ready) begin
      csum <= csum ^ msb_byte;
    end
  end
`endif

  // Next-state and output decode; outputs depend only on state so they hold
  // steady while a byte waits for tx_ready.
  always_comb begin
    state_nxt = state;
    stall_req = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_req = 1'b0;
        busy      = 1'b0;
        if (dump_req) state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (pipe_idle) state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        if (tx_ready) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = msb_byte;
        if (tx_ready) begin
          shift = 1'b1;
          if (last_byte) begin
            if (!last_reg) state_nxt = ST_LOAD;
`ifdef REGDUMP_CHECKSUM_EN
            else           state_nxt = ST_CSUM;
`else
            else           state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Self-checking bench for regfile_dump_sequencer: a cycle-exact timing table,
// randomised frames checked against a byte-list model, and corner sequences.
module tb_regfile_dump_sequencer;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        reset, dump_req, pipe_idle, tx_ready;
  logic        stall_req, busy, done, tx_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;

  logic [31:0] regs [NR];
  int vectors = 0;
  int miscompares = 0;
  byte unsigned got[$];
  byte unsigned exp_q[$];

  typedef struct {
    int         k;     // negedge index after the request edge
    logic [3:0] ctl;   // {stall_req, busy, tx_valid, done}
    int         addr;  // -1 = don't check
    int         data;  // -1 = don't check
  } row_t;
  row_t tbl[$];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .dump_req  (dump_req),
    .pipe_idle (pipe_idle),
    .stall_req (stall_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Frame model: header, every register big-endian, optional XOR of data bytes.
  task automatic build_expected();
    byte unsigned x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < NR; r++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(regs[r][8*b +: 8]);
        x = x ^ regs[r][8*b +: 8];
      end
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare_frame(input string name);
    int n;
    check({name, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_byte"}, got[i], exp_q[i]);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ctl"}, {stall_req, busy, done, tx_valid}, 4'b0000);
    check({name, "_data"}, tx_data, 8'h00);
    check({name, "_addr"}, rd_addr, 5'd0);
  endtask

  // Entered at the negedge where the DUT first shows STALL. Returns at the
  // negedge where done is observed (or after the cycle budget).
  task automatic collect(input int ready_pct, input int idle_delay, input bit keep_req,
                         output bit seen_done);
    bit         pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    seen_done = 1'b0;
    got.delete();
    for (int c = 0; c < 4000; c++) begin
      if (c <= idle_delay) check("stall_phase", {stall_req, tx_valid}, 2'b10);
      else if (c == idle_delay + 1) check("header", {tx_valid, tx_data}, {1'b1, 8'hA5});
      if (pv && !pr) check("hold_stable", {tx_valid, tx_data}, {1'b1, pd});
      dump_req  = keep_req;
      pipe_idle = (c >= idle_delay);
      tx_ready  = ($urandom_range(99) < ready_pct);
      if (tx_valid && tx_ready) got.push_back(tx_data);
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen_done) check("done_timeout", done, 1'b1);
  endtask

  task automatic run_dump(input int ready_pct, input int idle_delay, input string name);
    bit sd;
    dump_req  = 1'b1;
    pipe_idle = 1'b0;
    @(negedge clk);
    collect(ready_pct, idle_delay, 1'b0, sd);
    build_expected();
    compare_frame(name);
    @(negedge clk);
    check({name, "_idle"}, {stall_req, busy, done, tx_valid}, 4'b0000);
    @(negedge clk);
    check({name, "_quiet"}, busy, 1'b0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < NR; r++) regs[r] = r * 32'h01010101;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sd;
    bit found;

    reset = 1'b0; dump_req = 1'b0; pipe_idle = 1'b0; tx_ready = 1'b0;
    for (int r = 0; r < NR; r++) regs[r] = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Cycle-exact timing table, tx_ready and pipe_idle held high.
    tbl.push_back('{0,   4'b1100, 0,  -1});
    tbl.push_back('{1,   4'b1110, 0,  'hA5});
    tbl.push_back('{2,   4'b1100, 0,  -1});
    tbl.push_back('{3,   4'b1110, 0,  'h00});
    tbl.push_back('{6,   4'b1110, 0,  'h00});
    tbl.push_back('{7,   4'b1100, 1,  -1});
    tbl.push_back('{8,   4'b1110, 1,  'h01});
    tbl.push_back('{38,  4'b1110, 7,  'h07});
    tbl.push_back('{161, 4'b1110, 31, 'h1F});
`ifdef REGDUMP_CHECKSUM_EN
    tbl.push_back('{162, 4'b1110, 31, 'h00});
    tbl.push_back('{163, 4'b1101, 31, -1});
    tbl.push_back('{164, 4'b0000, -1, -1});
    tbl.push_back('{165, 4'b0000, -1, -1});
`else
    tbl.push_back('{162, 4'b1101, 31, -1});
    tbl.push_back('{163, 4'b0000, -1, -1});
    tbl.push_back('{164, 4'b0000, -1, -1});
`endif
    fill_ramp();
    dump_req = 1'b1; pipe_idle = 1'b1; tx_ready = 1'b1;
    got.delete();
    for (int k = 0; k <= 165; k++) begin
      @(negedge clk);
      dump_req = 1'b0;
      foreach (tbl[i]) begin
        if (tbl[i].k == k) begin
          check("tbl_ctl", {stall_req, busy, tx_valid, done}, tbl[i].ctl);
          if (tbl[i].addr >= 0) check("tbl_addr", rd_addr, tbl[i].addr);
          if (tbl[i].data >= 0) check("tbl_data", tx_data, tbl[i].data[7:0]);
        end
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
    end
    build_expected();
    compare_frame("ramp");
`ifdef REGDUMP_CHECKSUM_EN
    check("ramp_size", got.size(), 130);
`else
    check("ramp_size", got.size(), 129);
`endif

    // Drain held off for 10 cycles, then random back-pressure on the ramp data.
    run_dump(100, 10, "drain10");
    run_dump(50, 0, "ramp_bp");

    // Random register contents, random back-pressure and drain delay.
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_dump(30 + 20 * t, $urandom_range(0, 3), "rand");
    end

    // Reset pulse during register 7's SEND abandons the frame.
    fill_random();
    dump_req = 1'b1; pipe_idle = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rd_addr == 5'd7 && tx_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_reg7", {found, rd_addr}, {1'b1, 5'd7});
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    reset = 1'b1;
    run_dump(70, 2, "after_reset");

    // dump_req held high: one frame, IDLE for one cycle, then a second frame.
    fill_random();
    dump_req = 1'b1;
    @(negedge clk);
    collect(60, 1, 1'b1, sd);
    build_expected();
    compare_frame("held_f1");
    @(negedge clk);
    check("held_gap", {stall_req, busy}, 2'b00);
    @(negedge clk);
    check("held_restart", {stall_req, busy}, 2'b11);
    dump_req = 1'b0;
    collect(80, 0, 1'b0, sd);
    compare_frame("held_f2");
    @(negedge clk);
    check("held_end", {stall_req, busy}, 2'b00);

`ifdef REGDUMP_CHECKSUM_EN
    for (int r = 0; r < NR; r++) regs[r] = '0;
    regs[5] = 32'h000000FF;
    run_dump(60, 1, "csum_ff");
    check("csum_ff_last", (got.size() > 0) ? got[got.size()-1] : 8'h00, 8'hFF);
    regs[5] = '0;
    run_dump(60, 1, "csum_zero");
    check("csum_zero_last", (got.size() > 0) ? got[got.size()-1] : 8'hEE, 8'h00);
    check("csum_zero_size", got.size(), 130);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dump_sequencer.md
# regfile_dump_sequencer

Debug controller for the 32 x 32-bit register file in the decode stage. On request, it stalls the pipeline and waits for the pipeline to drain. It then walks register addresses 0..31 through the register file's debug read port and serialises every value as bytes over a valid/ready byte stream into the UART transmitter. It is the only block that drives the register file's debug read address, and it sits between the hazard/stall logic and the UART TX path.

## Interface
Parameters:
- NUM_REGS, 32, number of registers walked.
- DATA_W, 32, register width; must be a multiple of 8.
- ADDR_W, 5, register address width.
- HEADER_BYTE, 8'hA5, first byte of every dump frame.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- dump_req  in  1  level; sampled only in IDLE.
- pipe_idle  in  1  high when the pipeline is drained and writeback is quiet.
- stall_req  out  1  freezes the pipeline while a dump is in progress.
- rd_addr  out  ADDR_W  register file debug read address.
- rd_data  in  DATA_W  combinational read data for rd_addr.
- tx_data  out  8  byte to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the UART TX accepts the byte this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, STALL, HEADER, LOAD, SEND, CSUM (only with checksum), DONE.
- IDLE: when dump_req=1, go to STALL. Set stall_req=1 and rd_addr=0.
- STALL: hold until pipe_idle=1, then go to HEADER. pipe_idle is ignored in every other state.
- HEADER: tx_valid=1, tx_data=HEADER_BYTE. On the handshake, go to LOAD.
- LOAD: capture rd_data into a DATA_W shift register and clear the byte counter. Go to SEND after one cycle. tx_valid=0.
- SEND: tx_valid=1, tx_data is the shift-register MSB byte (big-endian). On each handshake, shift left by 8 and increment the byte counter.
  - After DATA_W/8 bytes, if rd_addr==NUM_REGS-1, go to CSUM or DONE.
  - Otherwise increment rd_addr and go to LOAD.
- CSUM: tx_data = XOR of all NUM_REGS*DATA_W/8 data bytes (header excluded), tx_valid=1. On the handshake, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. stall_req and busy drop on entering IDLE.
- Handshake rule: tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a handshake.
- dump_req held high through DONE starts a new dump on the following IDLE cycle. While busy, dump_req has no effect.
- Reset values, also applied on reset mid-dump on the next edge:
  - state IDLE
  - stall_req, busy, done and tx_valid all 0
  - tx_data 8'h00
  - rd_addr 0
  - checksum accumulator 0
  - A partial frame is abandoned, not resumed.

## Timing
- Request sampled at edge 0 gives stall_req=1 after edge 0.
- With pipe_idle=1 and tx_ready held at 1:
  - header accepted at edge 2
  - register n's bytes accepted at edges 4+5n .. 7+5n
  - last data byte accepted at edge 162
  - done high for the cycle after edge 162
  - stall_req and busy low after edge 163
- Checksum adds one byte and one cycle: last byte at edge 163, idle after edge 164.
- Each LOAD costs one bubble cycle per register.
- rd_addr is registered and stable for the whole LOAD cycle.
- Each cycle of tx_ready=0 while tx_valid=1 adds exactly one cycle.

## Configuration
- REGDUMP_CHECKSUM_EN:
  - Defined: the CSUM state and the 8-bit XOR accumulator exist, and the frame is 130 bytes.
  - Undefined: SEND goes straight to DONE, there is no accumulator, and the frame is 129 bytes.

## Structure
- Shared package `regdump_pkg`: state enum, HEADER_BYTE, byte-count constant DATA_W/8.
- A natural sub-module is `regdump_byte_shifter`. It holds the load/shift register, byte counter and MSB byte select, and has a load/shift interface.
- The FSM and address counter stay in the top module.

## Test plan
- rd_data model holds reg[n]=n×0x01010101, tx_ready=1, pipe_idle=1, dump_req pulse -> bytes A5, 00,00,00,00, 01,01,01,01 … 1F,1F,1F,1F. done pulses after edge 162, and stall_req is low after edge 163.
- pipe_idle held low for 10 cycles after the request -> stall_req=1 and tx_valid=0 throughout; the header appears the cycle after pipe_idle rises.
- tx_ready toggled 1/0 in a random pattern -> byte sequence identical to the first test, and tx_data never changes while tx_valid=1 and tx_ready=0.
- reset=0 for one cycle during register 7's SEND -> after the edge all outputs are at reset values. A new dump_req then produces a complete frame starting with A5.
- dump_req held high during a dump -> exactly one frame, then a second frame starts on the IDLE cycle after DONE.
- REGDUMP_CHECKSUM_EN defined, all registers 0 except reg5=0x000000FF -> final byte FF. With all registers 0 the final byte is 00, for 130 bytes in total.
